// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite plotter:
//   state_e        - plotter FSM states
//   ScreenW/H      - default visible screen size
//   BitmapW/H      - size of the built-in sprite bitmap
//   SpriteBitmap   - BitmapH rows of BitmapW bits; row 0 is the top row and
//                    the MSB of each row is the leftmost pixel
//   bitmap_bit()   - bitmap lookup, 0 outside the bitmap
// ----------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StErase,
        StDraw,
        StDone
    } state_e;

    localparam int unsigned ScreenW = 160;
    localparam int unsigned ScreenH = 120;

    localparam int unsigned BitmapW  = 8;
    localparam int unsigned BitmapH  = 4;
    localparam int unsigned BitmapXW = $clog2(BitmapW);
    localparam int unsigned BitmapYW = $clog2(BitmapH);

    localparam logic [BitmapW-1:0] SpriteBitmap [BitmapH] = '{
        8'b0011_1100,
        8'b0111_1110,
        8'b1101_1011,
        8'b1111_1111
    };

    // Sprites larger than the bitmap see transparent pixels outside it.
    function automatic logic bitmap_bit(input logic [7:0] dx, input logic [7:0] dy);
        logic [BitmapW-1:0] row;
        if (dx >= 8'(BitmapW) || dy >= 8'(BitmapH)) begin
            return 1'b0;
        end
        row = SpriteBitmap[dy[BitmapYW-1:0]];
        return row[BitmapXW'(8'(BitmapW - 1) - dx)];
    endfunction

endpackage

// File: rtl/box_scanner.sv
// ----------------------------------------------------------------------------
// box_scanner
// Row-major dx/dy counter over a SPRITE_W x SPRITE_H box. The counters hold
// the offset of the pixel currently being presented.
//   clk      in   system clock
//   reset_n  in   asynchronous active-high reset
//   clear    in   return counters to (0,0)
//   step     in   advance to the next pixel
//   dx_next  out  column of the pixel after the current one
//   dy_next  out  row of the pixel after the current one
//   last     out  current pixel is the last pixel of the box
// ----------------------------------------------------------------------------
module box_scanner #(
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned SPRITE_H = 4,
    localparam int unsigned DxW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
    localparam int unsigned DyW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           step,
    output logic [DxW-1:0] dx_next,
    output logic [DyW-1:0] dy_next,
    output logic           last
);

    logic [DxW-1:0] dx_q;
    logic [DyW-1:0] dy_q;
    logic           row_end;

    assign row_end = (dx_q == DxW'(SPRITE_W - 1));
    assign last    = row_end && (dy_q == DyW'(SPRITE_H - 1));
    assign dx_next = row_end ? '0 : dx_q + 1'b1;
    assign dy_next = row_end ? dy_q + 1'b1 : dy_q;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (clear) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (step) begin
            dx_q <= dx_next;
            dy_q <= dy_next;
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// ----------------------------------------------------------------------------
// sprite_plotter
// Erases a sprite at its previous position and redraws it at a new one, one
// pixel per cycle, driving a VGA adapter's pixel-write port.
//   clk        in   system clock
//   reset_n    in   asynchronous reset, active HIGH despite the name
//   go         in   one-cycle redraw request, ignored while busy
//   x_in       in   new top-left x
//   y_in       in   new top-left y
//   colour_in  in   sprite colour
//   alive      in   0: erase only, draw nothing
//   x_out      out  pixel x (scan address, valid when plot=1)
//   y_out      out  pixel y
//   colour_out out  pixel colour (holds last value when plot=0)
//   plot       out  pixel write enable
//   busy       out  high outside IDLE
//   done       out  one-cycle pulse when a redraw completes
// ----------------------------------------------------------------------------
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned SPRITE_H = 4,
    parameter int unsigned SCREEN_W = ScreenW,
    parameter int unsigned SCREEN_H = ScreenH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       alive,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DxW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned DyW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [8:0] ScrW = 9'(SCREEN_W);
    localparam logic [7:0] ScrH = 8'(SCREEN_H);

    state_e     state_q;
    logic [7:0] lat_x_q, prev_x_q;
    logic [6:0] lat_y_q, prev_y_q;
    logic [2:0] lat_colour_q;
    logic       lat_alive_q;
    logic       prev_valid_q;

    logic [DxW-1:0] dx_next;
    logic [DyW-1:0] dy_next;
    logic           last;
    logic           scan_clear, scan_step;

    // Next pixel to present, resolved for whichever phase follows this edge.
    logic       sel_erase, sel_alive;
    logic [7:0] base_x, scan_dx, scan_dy;
    logic [6:0] base_y;
    logic [2:0] sel_colour;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       pix_plot, load_pix;
    logic [2:0] pix_colour;

    assign busy       = (state_q != StIdle);
    assign scan_clear = (state_q == StErase || state_q == StDraw) && last;
    assign scan_step  = (state_q == StErase || state_q == StDraw) && !last;

    box_scanner #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_box_scanner (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (scan_clear),
        .step    (scan_step),
        .dx_next (dx_next),
        .dy_next (dy_next),
        .last    (last)
    );

    always_comb begin
        sel_erase  = 1'b0;
        sel_alive  = lat_alive_q;
        sel_colour = lat_colour_q;
        base_x     = lat_x_q;
        base_y     = lat_y_q;
        scan_dx    = '0;
        scan_dy    = '0;
        load_pix   = 1'b0;
        case (state_q)
            StIdle: begin
                load_pix   = go;
                sel_alive  = alive;
                sel_colour = colour_in;
                if (prev_valid_q) begin
                    sel_erase = 1'b1;
                    base_x    = prev_x_q;
                    base_y    = prev_y_q;
                end else begin
                    base_x = x_in;
                    base_y = y_in;
                end
            end
            StErase: begin
                load_pix = 1'b1;
                // On the last erase pixel the next one is draw pixel (0,0).
                if (!last) begin
                    sel_erase = 1'b1;
                    base_x    = prev_x_q;
                    base_y    = prev_y_q;
                    scan_dx   = 8'(dx_next);
                    scan_dy   = 8'(dy_next);
                end
            end
            StDraw: begin
                load_pix = !last;
                scan_dx  = 8'(dx_next);
                scan_dy  = 8'(dy_next);
            end
            default: ;
        endcase

        // One bit wider than the base so off-screen pixels never wrap back on.
        sum_x      = 9'(base_x) + 9'(scan_dx);
        sum_y      = 8'(base_y) + scan_dy;
        pix_plot   = (sum_x < ScrW) && (sum_y < ScrH) &&
                     (sel_erase || (sel_alive && bitmap_bit(scan_dx, scan_dy)));
        pix_colour = sel_erase ? 3'b000 : sel_colour;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= StIdle;
            lat_x_q      <= '0;
            lat_y_q      <= '0;
            lat_colour_q <= '0;
            lat_alive_q  <= 1'b0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            colour_out   <= '0;
            plot         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (go) begin
                        lat_x_q      <= x_in;
                        lat_y_q      <= y_in;
                        lat_colour_q <= colour_in;
                        lat_alive_q  <= alive;
                        state_q      <= prev_valid_q ? StErase : StDraw;
                    end
                end
                StErase: begin
                    if (last) begin
                        state_q <= StDraw;
                    end
                end
                StDraw: begin
                    if (last) begin
                        state_q <= StDone;
                        plot    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    done         <= 1'b0;
                    state_q      <= StIdle;
                    prev_x_q     <= lat_x_q;
                    prev_y_q     <= lat_y_q;
                    prev_valid_q <= lat_alive_q;
                end
                default: state_q <= StIdle;
            endcase

            if (load_pix) begin
                x_out <= sum_x[7:0];
                y_out <= sum_y[6:0];
                plot  <= pix_plot;
                if (pix_plot) begin
                    colour_out <= pix_colour;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
module tb_sprite_plotter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       go;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic       alive;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    sprite_plotter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .alive      (alive),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncnt  = 0;

    int   model_prev_x = 0;
    int   model_prev_y = 0;
    bit   model_prev_valid = 1'b0;

    logic [7:0] bm_rows [4] = '{8'b0011_1100, 8'b0111_1110, 8'b1101_1011, 8'b1111_1111};

    always @(posedge clk) ncnt <= ncnt + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit bm(input int dx, input int dy);
        logic [7:0] row;
        row = bm_rows[dy[1:0]];
        return row[3'(7 - dx)];
    endfunction

    // Scoreboard: every plotted pixel must be the next expected one, on time.
    always @(negedge clk) begin
        if (!reset_n && plot) begin
            check("plot_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("plot_x", int'(x_out), mon_e.x);
                check("plot_y", int'(y_out), mon_e.y);
                check("plot_colour", int'(colour_out), mon_e.c);
                check("plot_time", ncnt, mon_e.t);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_plot"}, int'(plot), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_x"}, int'(x_out), 0);
        check({tag, "_y"}, int'(y_out), 0);
        check({tag, "_colour"}, int'(colour_out), 0);
    endtask

    // One redraw request; reset_at / pulse_at are cycles after go (0 = none).
    task automatic do_go(input int x, input int y, input int c, input int a,
                         input int reset_at, input int pulse_at);
        int   base, phases, rel, dcount, done_rel, idx, sx, sy;
        pix_t e;
        phases = model_prev_valid ? 2 : 1;
        @(negedge clk);
        go        = 1'b1;
        x_in      = 8'(x);
        y_in      = 7'(y);
        colour_in = 3'(c);
        alive     = (a != 0);
        base      = ncnt;
        idx       = 0;
        if (model_prev_valid) begin
            for (int dy = 0; dy < 4; dy++) begin
                for (int dx = 0; dx < 8; dx++) begin
                    sx = model_prev_x + dx;
                    sy = model_prev_y + dy;
                    if (sx < 160 && sy < 120) begin
                        e.x = sx; e.y = sy; e.c = 0; e.t = base + 1 + idx;
                        exp_q.push_back(e);
                    end
                    idx++;
                end
            end
        end
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                sx = x + dx;
                sy = y + dy;
                if (sx < 160 && sy < 120 && a != 0 && bm(dx, dy)) begin
                    e.x = sx; e.y = sy; e.c = c; e.t = base + 1 + idx;
                    exp_q.push_back(e);
                end
                idx++;
            end
        end
        dcount   = 0;
        done_rel = -1;
        for (int n = 0; n < 32 * phases + 40; n++) begin
            @(negedge clk);
            rel = ncnt - base;
            go  = 1'b0;
            if (rel == pulse_at) begin
                go = 1'b1; x_in = 8'd0; y_in = 7'd0; colour_in = 3'd1; alive = 1'b1;
            end
            if (rel == 1) check("busy_after_go", int'(busy), 1);
            if (rel == reset_at) begin
                reset_n = 1'b1;
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                reset_n = 1'b0;
                exp_q.delete();
                model_prev_valid = 1'b0;
                return;
            end
            if (done) begin
                dcount++;
                if (done_rel < 0) done_rel = rel;
                check("plot_at_done", int'(plot), 0);
            end
        end
        go = 1'b0;
        check("done_count", dcount, 1);
        check("done_cycle", done_rel, 1 + 32 * phases);
        check("busy_idle", int'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
        model_prev_valid = (a != 0);
        if (a != 0) begin
            model_prev_x = x;
            model_prev_y = y;
        end
    endtask

    initial begin
        reset_n   = 1'b1;
        go        = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        alive     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b0;

        do_go(10, 20, 7, 1, 0, 0);    // first draw, no erase
        do_go(12, 20, 3, 1, 0, 0);    // erase + draw
        do_go(156, 50, 2, 1, 0, 0);   // right-edge clipping
        do_go(100, 118, 6, 1, 0, 0);  // bottom-edge clipping
        do_go(40, 40, 1, 0, 0, 0);    // dead: erase only
        do_go(50, 60, 6, 1, 0, 0);    // dead sprite not erased again
        do_go(70, 30, 4, 1, 0, 40);   // go pulsed mid-DRAW is ignored
        do_go(20, 20, 5, 1, 10, 0);   // reset on 10th erase cycle
        do_go(30, 30, 5, 1, 0, 0);    // skips erase after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
